mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 31 +++
 rtl/sign_fix.sv | 16 +
 rtl/mul_div_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e        : MULT/MULTU/DIV/DIVU operation encodings driven on `op`
//   state_e     : control FSM states (IDLE, BUSY, DONE)
//   ITER_COUNT  : radix-2 iterations per multiply or divide
//   is_signed_op/is_div_op : decode helpers shared by the datapath
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int ITER_COUNT = 32;

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/sign_fix.sv
// Conditional two's-complement negation.
//   din  : value to correct
//   neg  : 1 = output -din, 0 = pass din through
//   dout : corrected value
// Used for taking operand magnitudes and for restoring result signs.
module sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? ((~din) + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle on a shared 2*DATA_W accumulator: shift-add
// for multiply, restoring subtraction for divide. Signed operations work on
// magnitudes and fix the result signs on the final step.
//   clk, rst    : clock, asynchronous active-high reset
//   start, op   : request and operation code (accepted in IDLE or DONE)
//   src_a/src_b : Rs / Rt operands
//   flush       : abort in-flight operation, drop a same-cycle start
//   hilo_we     : MTHI/MTLO write enables [1]=HI [0]=LO, data on hilo_wdata
//   busy        : operation in progress
//   done        : one-cycle completion pulse (DONE state)
//   div_by_zero : coincident with done when a divide had a zero divisor
//   HI, LO      : architectural result registers
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    input  logic [1:0]        hilo_we,
    input  logic [DATA_W-1:0] hilo_wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    localparam int         AW       = 2 * DATA_W;
    localparam logic [5:0] LAST_CNT = 6'(ITER_COUNT - 1);

    state_e state, state_nxt;

    logic [5:0]        cnt;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_step;
    logic [DATA_W-1:0] b_r;
    logic              is_div_r;
    logic              dz_r;
    logic              neg_lo_r;   // product or quotient must be negated
    logic              neg_hi_r;   // remainder must be negated

    op_e               op_in;
    logic              signed_op;
    logic              div_op;
    logic              dz_in;
    logic              accept;
    logic              last_iter;
    logic              complete;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;
    logic [AW-1:0]     prod_fix;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;

    assign op_in     = op_e'(op);
    assign signed_op = is_signed_op(op_in);
    assign div_op    = is_div_op(op_in);
    assign dz_in     = div_op && (src_b == '0);
    // flush has priority over start; BUSY never accepts a new request
    assign accept    = start && !flush && (state != BUSY);

    sign_fix #(.W(DATA_W)) u_abs_a (
        .din  (src_a),
        .neg  (signed_op & src_a[DATA_W-1]),
        .dout (abs_a)
    );

    sign_fix #(.W(DATA_W)) u_abs_b (
        .din  (src_b),
        .neg  (signed_op & src_b[DATA_W-1]),
        .dout (abs_b)
    );

    // Multiply: add multiplier into the upper half when the LSB of the
    // shifting multiplicand is set, then shift right with the carry.
    assign add_sum = {1'b0, acc[AW-1:DATA_W]} + {1'b0, b_r};

    // Divide: upper half holds the partial remainder, lower half shifts the
    // dividend out and quotient bits in. The remainder stays below the
    // divisor, so one extra bit is enough to detect the borrow.
    assign rem_sh = acc[AW-1:DATA_W-1];
    assign diff   = rem_sh - {1'b0, b_r};

    always_comb begin
        acc_step = acc;
        if (is_div_r) begin
            if (!diff[DATA_W]) begin
                acc_step = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end else begin
                acc_step = {acc[AW-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_step = {add_sum, acc[DATA_W-1:1]};
            end else begin
                acc_step = {1'b0, acc[AW-1:1]};
            end
        end
    end

    // Sign correction applied to the value produced by the final step
    sign_fix #(.W(AW)) u_fix_prod (
        .din  (acc_step),
        .neg  (neg_lo_r),
        .dout (prod_fix)
    );

    sign_fix #(.W(DATA_W)) u_fix_quo (
        .din  (acc_step[DATA_W-1:0]),
        .neg  (neg_lo_r),
        .dout (quo_fix)
    );

    sign_fix #(.W(DATA_W)) u_fix_rem (
        .din  (acc_step[AW-1:DATA_W]),
        .neg  (neg_hi_r),
        .dout (rem_fix)
    );

    assign res_hi = is_div_r ? rem_fix : prod_fix[AW-1:DATA_W];
    assign res_lo = is_div_r ? quo_fix : prod_fix[DATA_W-1:0];

    // A zero divisor finishes after a single BUSY cycle
    assign last_iter = dz_r || (cnt == LAST_CNT);
    assign complete  = (state == BUSY) && !flush && last_iter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                div_by_zero = dz_r;
                state_nxt   = accept ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dz_r <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            if (accept) begin
                cnt  <= '0;
                dz_r <= dz_in;
            end else if (state == BUSY) begin
                cnt <= cnt + 6'd1;
            end

            if (complete) begin
                if (dz_r) begin
                    // accumulator was loaded with the raw dividend
                    HI <= acc[DATA_W-1:0];
                    LO <= '1;
                end else begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end else if (state != BUSY) begin
                if (hilo_we[1]) HI <= hilo_wdata;
                if (hilo_we[0]) LO <= hilo_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            acc      <= {{DATA_W{1'b0}}, (dz_in ? src_a : abs_a)};
            b_r      <= abs_b;
            is_div_r <= div_op;
            neg_lo_r <= signed_op & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            neg_hi_r <= signed_op & src_a[DATA_W-1];
        end else if (state == BUSY) begin
            acc <= acc_step;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: driver pushes expected results from
// an arithmetic reference model; a negedge monitor pops on every done.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [1:0]  hilo_we = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [31:0] hilo_wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int s;
    int ndone;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .hilo_we     (hilo_we),
        .hilo_wdata  (hilo_wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: plain 64-bit arithmetic with SV truncating division
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        e.dz = 1'b0;
        e.due = 0;
        e.hi = '0;
        e.lo = '0;
        if (o == 2'b00) begin
            p = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (o == 2'b01) begin
            p = {32'b0, a} * {32'b0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end else if (o == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            e.lo = 32'(q);
            e.hi = 32'(r);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_done HI=%h LO=%h", HI, LO);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result_hi", 64'(HI), 64'(mon_e.hi));
                chk("result_lo", 64'(LO), 64'(mon_e.lo));
                chk("div_by_zero_flag", 64'(div_by_zero), 64'(mon_e.dz));
                chk("done_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end else if (!rst && div_by_zero) begin
            nchk++;
            nerr++;
            $display("FAIL dz_without_done actual=1 required=0");
        end
    end

    // Called at a negedge. inject>=0 pulses a stray start and MTHI/MTLO
    // that many cycles into BUSY; they must have no effect.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int inject);
        exp_t        e;
        logic [31:0] ph;
        logic [31:0] pl;
        bit          got;
        ph = hilo_we[1] ? hilo_wdata : m_hi;
        pl = hilo_we[0] ? hilo_wdata : m_lo;
        e = model(o, a, b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        e.due = cyc + (e.dz ? 1 : ITER_COUNT);
        sb_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        hilo_we = 2'b00;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("hilo_during_busy", {HI, LO}, {ph, pl});
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (i == inject) begin
                start      = 1'b1;
                op         = 2'b01;
                src_a      = 32'h0000_1234;
                src_b      = 32'h0000_5678;
                hilo_we    = 2'b11;
                hilo_wdata = 32'hDEAD_BEEF;
            end else begin
                start   = 1'b0;
                hilo_we = 2'b00;
            end
            @(negedge clk);
        end
        start   = 1'b0;
        hilo_we = 2'b00;
        if (!got) begin
            nchk++;
            nerr++;
            $display("FAIL done_timeout op=%0d actual=no_done required=done", o);
        end
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic mt(input logic [1:0] we, input logic [31:0] d);
        hilo_we    = we;
        hilo_wdata = d;
        @(negedge clk);
        hilo_we = 2'b00;
        if (we[1]) m_hi = d;
        if (we[0]) m_lo = d;
        chk("mthi_mtlo", {HI, LO}, {m_hi, m_lo});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (2) @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, div_by_zero}), 64'd0);
        chk("reset_hilo", {HI, LO}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(2'b00, 32'hFFFF_FFFE, 32'd3, -1);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
        do_op(2'b11, 32'd7, 32'd2, -1);
        do_op(2'b11, 32'd5, 32'd0, -1);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 10);

        // MTHI/MTLO together with start: write lands, result overwrites
        hilo_we    = 2'b11;
        hilo_wdata = 32'h1234_5678;
        do_op(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
        @(negedge clk);
        chk("idle_after_done", 64'({busy, done}), 64'd0);

        // flush beats start in IDLE
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        src_a = 32'd1;
        src_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_beats_start", 64'(busy), 64'd0);

        // flush mid-operation
        mt(2'b10, 32'h0000_AAAA);
        mt(2'b01, 32'h0000_5555);
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd3;
        src_b = 32'd4;
        @(posedge clk);
        #1;
        s = cyc;
        @(negedge clk);
        start      = 1'b0;
        hilo_we    = 2'b11;
        hilo_wdata = 32'h0000_DEAD;
        @(negedge clk);
        hilo_we = 2'b00;
        while (cyc < s + 9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hilo", {HI, LO}, {32'h0000_AAAA, 32'h0000_5555});
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("flush_no_done", 64'(ndone), 64'd0);
        do_op(2'b00, 32'd3, 32'd4, -1);

        for (int k = 0; k < 30; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                3: begin ra = 32'h8000_0000; rb = $urandom; end
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, -1);
        end

        // reset during a DIV, with a stray start while busy
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        src_a = 32'd100;
        src_b = 32'd7;
        @(posedge clk);
        #1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 4) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd9;
        src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignores_start", 64'(busy), 64'd1);
        while (cyc < s + 19) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ctrl", 64'({busy, done, div_by_zero}), 64'd0);
        chk("async_rst_hilo", {HI, LO}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        do_op(2'b11, 32'd100, 32'd7, -1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
